// File: rtl/hack_core.sv
// Single-cycle Hack CPU: A/D registers, data RAM, memory-mapped output and keyboard,
// and a HALT state entered by an unconditional jump to its own address.
module hack_core #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 15,
   parameter int RAM_DEPTH = 16384,
   parameter int OUT_ADDR  = 16384,
   parameter int KBD_ADDR  = 24576
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] instr,
   input  logic              instr_valid,
   input  logic [DATA_W-1:0] kbd,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              halted
);
   localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam logic [DATA_W-1:0] RAM_LIMIT = DATA_W'(RAM_DEPTH);
   localparam logic [DATA_W-1:0] OUT_A     = DATA_W'(OUT_ADDR);
   localparam logic [DATA_W-1:0] KBD_A     = DATA_W'(KBD_ADDR);

   typedef enum logic {RUN, HALT} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [DATA_W-1:0] a_reg, a_next;
   logic [DATA_W-1:0] d_reg, d_next;
   logic [DATA_W-1:0] out_reg, out_next;
   logic              out_valid_reg, out_valid_next;
   logic              ram_we;

   logic [DATA_W-1:0] ram [RAM_DEPTH];

   logic              is_c, a_sel;
   logic [5:0]        comp;
   logic [2:0]        dest, jmp;
   logic              unused_bits;

   assign is_c        = instr[DATA_W-1];
   assign a_sel       = instr[12];
   assign comp        = instr[11:6];
   assign dest        = instr[5:3];
   assign jmp         = instr[2:0];
   assign unused_bits = ^instr[DATA_W-2:13];

   logic [DATA_W-1:0] m_val, alu_y, x_zx, x_op, y_zy, y_op, alu_raw, alu_res;
   logic              comp_ok, take;
   logic              in_ram;

   assign in_ram = (a_reg < RAM_LIMIT);

   always_comb begin
      if (in_ram)
         m_val = ram[a_reg[RAM_AW-1:0]];
      else if (a_reg == OUT_A)
         m_val = out_reg;
      else if (a_reg == KBD_A)
         m_val = kbd;
      else
         m_val = '0;
   end

   // Only the 28 documented (a, comp) pairs are legal; anything else forces a zero result.
   always_comb begin
      if (a_sel)
         comp_ok = comp inside {6'b110000, 6'b110001, 6'b110011, 6'b110111, 6'b110010,
                                6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};
      else
         comp_ok = comp inside {6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                                6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                                6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                                6'b000111, 6'b000000, 6'b010101};
   end

   // Classic zx/nx/zy/ny/f/no ALU datapath.
   always_comb begin
      alu_y   = a_sel ? m_val : a_reg;
      x_zx    = comp[5] ? '0 : d_reg;
      x_op    = comp[4] ? ~x_zx : x_zx;
      y_zy    = comp[3] ? '0 : alu_y;
      y_op    = comp[2] ? ~y_zy : y_zy;
      alu_raw = comp[1] ? (x_op + y_op) : (x_op & y_op);
      alu_res = comp_ok ? (comp[0] ? ~alu_raw : alu_raw) : '0;
   end

   always_comb begin
      case (jmp)
         3'b000:  take = 1'b0;
         3'b001:  take = !alu_res[DATA_W-1] && (alu_res != '0);
         3'b010:  take = (alu_res == '0);
         3'b011:  take = !alu_res[DATA_W-1];
         3'b100:  take = alu_res[DATA_W-1];
         3'b101:  take = (alu_res != '0);
         3'b110:  take = alu_res[DATA_W-1] || (alu_res == '0);
         default: take = 1'b1;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      pc_next        = pc_reg;
      a_next         = a_reg;
      d_next         = d_reg;
      out_next       = out_reg;
      out_valid_next = 1'b0;
      ram_we         = 1'b0;
      if (state_reg == RUN && instr_valid) begin
         if (!is_c) begin
            a_next  = DATA_W'(instr[ADDR_W-1:0]);
            pc_next = pc_reg + ADDR_W'(1);
         end else begin
            if (dest[2]) a_next = alu_res;
            if (dest[1]) d_next = alu_res;
            if (dest[0]) begin
               ram_we = in_ram;
               if (a_reg == OUT_A) begin
                  out_next       = alu_res;
                  out_valid_next = 1'b1;
               end
            end
            if (take) begin
               pc_next = a_reg[ADDR_W-1:0];
               if (jmp == 3'b111 && a_reg[ADDR_W-1:0] == pc_reg)
                  state_next = HALT;
            end else begin
               pc_next = pc_reg + ADDR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= RUN;
         pc_reg        <= '0;
         a_reg         <= '0;
         d_reg         <= '0;
         out_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         a_reg         <= a_next;
         d_reg         <= d_next;
         out_reg       <= out_next;
         out_valid_reg <= out_valid_next;
      end
   end

   // RAM has no reset; gating with rst_n keeps an edge under reset from committing a store.
   always_ff @(posedge clk) begin
      if (ram_we && rst_n)
         ram[a_reg[RAM_AW-1:0]] <= alu_res;
   end

   assign pc        = pc_reg;
   assign out_data  = out_reg;
   assign out_valid = out_valid_reg;
   assign halted    = (state_reg == HALT);
endmodule

// File: tb/tb_hack_core.sv
// Self-checking bench for hack_core: directed program scenarios plus random programs
// compared against an instruction-level reference model.
module tb_hack_core;
   localparam logic [2:0] DA = 3'b100, DD = 3'b010, DM = 3'b001;
   localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111, C_NEG1 = 6'b111010,
                          C_D = 6'b001100, C_NOTD = 6'b001101, C_NEGD = 6'b001111,
                          C_DP1 = 6'b011111, C_DM1 = 6'b001110, C_A = 6'b110000,
                          C_NOTA = 6'b110001, C_NEGA = 6'b110011, C_AP1 = 6'b110111,
                          C_AM1 = 6'b110010, C_DPA = 6'b000010, C_DMA = 6'b010011,
                          C_AMD = 6'b000111, C_DANDA = 6'b000000, C_DORA = 6'b010101;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic [15:0] kbd = '0;
   logic [14:0] pc;
   logic [15:0] out_data;
   logic        out_valid, halted;

   logic [31:0] instr32 = '0;
   logic        valid32 = 1'b0;
   logic [31:0] kbd32 = '0;
   logic [14:0] pc32;
   logic [31:0] out32;
   logic        ov32, h32;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [14:0] m_pc;
   logic [15:0] m_a, m_d, m_out;
   logic        m_outv, m_halt;
   logic [15:0] m_ram [int];

   logic [5:0] comp_tab [18] = '{C_ZERO, C_ONE, C_NEG1, C_D, C_NOTD, C_NEGD, C_DP1, C_DM1,
                                 C_A, C_NOTA, C_NEGA, C_AP1, C_AM1, C_DPA, C_DMA, C_AMD,
                                 C_DANDA, C_DORA};

   hack_core dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .kbd(kbd),
      .pc(pc), .out_data(out_data), .out_valid(out_valid), .halted(halted)
   );

   hack_core #(.DATA_W(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .instr(instr32), .instr_valid(valid32), .kbd(kbd32),
      .pc(pc32), .out_data(out32), .out_valid(ov32), .halted(h32)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] ains(input int v);
      logic [15:0] t;
      t = 16'(v);
      return {1'b0, t[14:0]};
   endfunction

   function automatic logic [15:0] cins(input logic a, input logic [5:0] c,
                                        input logic [2:0] d, input logic [2:0] j);
      return {3'b111, a, c, d, j};
   endfunction

   function automatic logic [15:0] model_alu(input logic a, input logic [5:0] c,
                                             input logic [15:0] x, input logic [15:0] y);
      logic [15:0] r;
      logic uses_y, ok;
      uses_y = 1'b1;
      ok = 1'b1;
      case (c)
         C_ZERO:  begin r = 16'd0;       uses_y = 1'b0; end
         C_ONE:   begin r = 16'd1;       uses_y = 1'b0; end
         C_NEG1:  begin r = 16'hFFFF;    uses_y = 1'b0; end
         C_D:     begin r = x;           uses_y = 1'b0; end
         C_NOTD:  begin r = ~x;          uses_y = 1'b0; end
         C_NEGD:  begin r = 16'd0 - x;   uses_y = 1'b0; end
         C_DP1:   begin r = x + 16'd1;   uses_y = 1'b0; end
         C_DM1:   begin r = x - 16'd1;   uses_y = 1'b0; end
         C_A:     r = y;
         C_NOTA:  r = ~y;
         C_NEGA:  r = 16'd0 - y;
         C_AP1:   r = y + 16'd1;
         C_AM1:   r = y - 16'd1;
         C_DPA:   r = x + y;
         C_DMA:   r = x - y;
         C_AMD:   r = y - x;
         C_DANDA: r = x & y;
         C_DORA:  r = x | y;
         default: begin r = 16'd0; ok = 1'b0; end
      endcase
      return (ok && (!a || uses_y)) ? r : 16'd0;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] addr);
      if (addr < 16'd16384) return m_ram.exists(int'(addr)) ? m_ram[int'(addr)] : 16'd0;
      if (addr == 16'd16384) return m_out;
      if (addr == 16'd24576) return kbd;
      return 16'd0;
   endfunction

   task automatic model_reset();
      m_pc = '0; m_a = '0; m_d = '0; m_out = '0; m_outv = 1'b0; m_halt = 1'b0;
   endtask

   task automatic model_step(input logic [15:0] ins, input logic v);
      logic [15:0] y, res, old_a;
      logic signed [15:0] sr;
      logic t;
      m_outv = 1'b0;
      if (m_halt || !v) return;
      if (!ins[15]) begin
         m_a = {1'b0, ins[14:0]};
         m_pc = m_pc + 15'd1;
         return;
      end
      old_a = m_a;
      y = ins[12] ? model_read(old_a) : old_a;
      res = model_alu(ins[12], ins[11:6], m_d, y);
      sr = $signed(res);
      case (ins[2:0])
         3'd0: t = 1'b0;
         3'd1: t = sr > 0;
         3'd2: t = sr == 0;
         3'd3: t = sr >= 0;
         3'd4: t = sr < 0;
         3'd5: t = sr != 0;
         3'd6: t = sr <= 0;
         default: t = 1'b1;
      endcase
      if (ins[5]) m_a = res;
      if (ins[4]) m_d = res;
      if (ins[3]) begin
         if (old_a < 16'd16384) m_ram[int'(old_a)] = res;
         else if (old_a == 16'd16384) begin m_out = res; m_outv = 1'b1; end
      end
      if (t) begin
         if (ins[2:0] == 3'b111 && old_a[14:0] == m_pc) m_halt = 1'b1;
         m_pc = old_a[14:0];
      end else begin
         m_pc = m_pc + 15'd1;
      end
   endtask

   task automatic step(input logic [15:0] ins, input logic v);
      instr = ins;
      instr_valid = v;
      model_step(ins, v);
      @(posedge clk);
      #1;
      $display("t=%0t instr=%h valid=%b pc=%h out=%h ov=%b halted=%b",
               $time, ins, v, pc, out_data, out_valid, halted);
   endtask

   task automatic step32(input logic [31:0] ins);
      instr32 = ins;
      valid32 = 1'b1;
      @(posedge clk);
      #1;
      valid32 = 1'b0;
      $display("t=%0t instr32=%h pc32=%h out32=%h ov32=%b", $time, ins, pc32, out32, ov32);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      instr_valid = 1'b0;
      valid32 = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   function automatic logic [15:0] gen_instr();
      int r, k;
      logic [15:0] v;
      logic a;
      logic [5:0] c;
      r = $urandom_range(0, 99);
      if (r < 40) begin
         case ($urandom_range(0, 6))
            0, 1:    v = 16'($urandom_range(0, 15));
            2:       v = 16'd16384;
            3:       v = 16'd24576;
            4:       v = 16'd20000;
            5:       v = {1'b0, m_pc + 15'd1};
            default: v = 16'($urandom);
         endcase
         return {1'b0, v[14:0]};
      end
      if (r < 90) begin
         k = $urandom_range(0, 17);
         c = comp_tab[k];
         a = (k >= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
         c = 6'($urandom);
         a = 1'($urandom);
      end
      // Never read a RAM word the program has not written yet.
      if (a && m_a < 16'd16384 && !m_ram.exists(int'(m_a))) a = 1'b0;
      return {1'b1, 2'($urandom), a, c, 3'($urandom),
              ($urandom_range(0, 9) < 3) ? 3'($urandom) : 3'b000};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (pc !== 15'd0) begin n_errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
      n_checks++; if (out_data !== 16'd0) begin n_errors++; $display("FAIL reset_out: got %h expected 0", out_data); end
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_ov: got %b expected 0", out_valid); end
      n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_out_sum();
      do_reset();
      step(ains(5), 1'b1);
      n_checks++; if (pc !== 15'd1) begin n_errors++; $display("FAIL first_exec_pc: got %h expected 1", pc); end
      step(cins(0, C_A, DD, 0), 1'b1);
      step(ains(3), 1'b1);
      step(cins(0, C_DPA, DD, 0), 1'b1);
      step(ains(16384), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'd8) begin n_errors++; $display("FAIL sum_out: got %h expected 8", out_data); end
      n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL sum_ov: got %b expected 1", out_valid); end
      n_checks++; if (pc !== 15'd6) begin n_errors++; $display("FAIL sum_pc: got %h expected 6", pc); end
      step(cins(0, C_ONE, DD, 0), 1'b1);
      n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL sum_pulse: got %b expected 0", out_valid); end
      n_checks++; if (out_data !== 16'd8) begin n_errors++; $display("FAIL sum_hold: got %h expected 8", out_data); end
   endtask

   task automatic test_jump();
      do_reset();
      step(ains(7), 1'b1);
      step(cins(0, C_A, DD, 0), 1'b1);
      step(ains(10), 1'b1);
      step(cins(0, C_D, 3'b000, 3'b001), 1'b1);
      n_checks++; if (pc !== 15'd10) begin n_errors++; $display("FAIL jgt_taken: got %h expected 10", pc); end
      do_reset();
      step(ains(1), 1'b1);
      step(cins(0, C_NEGA, DD, 0), 1'b1);
      step(ains(10), 1'b1);
      step(cins(0, C_D, 3'b000, 3'b001), 1'b1);
      n_checks++; if (pc !== 15'd4) begin n_errors++; $display("FAIL jgt_not_taken: got %h expected 4", pc); end
      step(cins(0, C_D, 3'b000, 3'b100), 1'b1);
      n_checks++; if (pc !== 15'd10) begin n_errors++; $display("FAIL jlt_taken: got %h expected 10", pc); end
   endtask

   task automatic test_am_update();
      do_reset();
      step(ains(100), 1'b1);
      step(cins(0, C_AP1, DA | DM, 0), 1'b1);
      step(cins(0, C_A, DD, 0), 1'b1);
      step(ains(16384), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'd101) begin n_errors++; $display("FAIL am_a: got %0d expected 101", out_data); end
      step(ains(100), 1'b1);
      step(cins(1, C_A, DD, 0), 1'b1);
      step(ains(16384), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'd101) begin n_errors++; $display("FAIL am_ram: got %0d expected 101", out_data); end
   endtask

   task automatic test_kbd();
      do_reset();
      kbd = 16'h0041;
      step(ains(24576), 1'b1);
      step(cins(1, C_A, DD, 0), 1'b1);
      step(ains(16384), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'h0041) begin n_errors++; $display("FAIL kbd_read: got %h expected 0041", out_data); end
      step(cins(1, C_AP1, DD, 0), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'h0042) begin n_errors++; $display("FAIL out_readback: got %h expected 0042", out_data); end
   endtask

   task automatic test_stall();
      logic [15:0] prog [10];
      logic [15:0] ref_out;
      logic [14:0] ref_pc, held_pc;
      prog = '{ains(5), cins(0, C_A, DD, 0), ains(3), cins(0, C_DPA, DD, 0), ains(16384),
               cins(0, C_D, DM, 0), ains(9), cins(0, C_DPA, DD, 0), ains(16384),
               cins(0, C_D, DM, 0)};
      do_reset();
      for (int i = 0; i < 10; i++) step(prog[i], 1'b1);
      ref_out = m_out;
      ref_pc = m_pc;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(prog[i], 1'b1);
         if (i == 5) begin
            held_pc = m_pc;
            for (int s = 0; s < 3; s++) begin
               step(16'($urandom) | 16'h8000, 1'b0);
               n_checks++; if (pc !== held_pc) begin n_errors++; $display("FAIL stall_pc %0d: got %h expected %h", s, pc, held_pc); end
               n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_ov %0d: got %b expected 0", s, out_valid); end
            end
         end
      end
      n_checks++; if (out_data !== ref_out) begin n_errors++; $display("FAIL stall_result: got %h expected %h", out_data, ref_out); end
      n_checks++; if (pc !== ref_pc) begin n_errors++; $display("FAIL stall_final_pc: got %h expected %h", pc, ref_pc); end
   endtask

   task automatic test_halt();
      do_reset();
      step(ains(0), 1'b1);
      step(ains(0), 1'b1);
      step(ains(0), 1'b1);
      step(ains(4), 1'b1);
      step(cins(0, C_ONE, DD, 3'b111), 1'b1);
      n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_enter: got %b expected 1", halted); end
      for (int i = 0; i < 5; i++) begin
         step(16'($urandom), 1'($urandom));
         n_checks++; if (pc !== 15'd4) begin n_errors++; $display("FAIL halt_pc %0d: got %h expected 4", i, pc); end
         n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_hold %0d: got %b expected 1", i, halted); end
      end
      rst_n = 1'b0;
      #2;
      n_checks++; if (pc !== 15'd0) begin n_errors++; $display("FAIL halt_async_pc: got %h expected 0", pc); end
      n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_async_clear: got %b expected 0", halted); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      step(ains(0), 1'b1);
      n_checks++; if (pc !== 15'd1) begin n_errors++; $display("FAIL halt_restart: got %h expected 1", pc); end
   endtask

   task automatic test_reset_abort();
      do_reset();
      step(ains(7), 1'b1);
      step(cins(0, C_A, DD, 0), 1'b1);
      step(ains(50), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      step(cins(0, C_DP1, DD, 0), 1'b1);
      instr = cins(0, C_D, DM, 0);
      instr_valid = 1'b1;
      #3;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++; if (pc !== 15'd0) begin n_errors++; $display("FAIL abort_pc: got %h expected 0", pc); end
      rst_n = 1'b1;
      model_reset();
      step(ains(50), 1'b1);
      step(cins(1, C_A, DD, 0), 1'b1);
      step(ains(16384), 1'b1);
      step(cins(0, C_D, DM, 0), 1'b1);
      n_checks++; if (out_data !== 16'd7) begin n_errors++; $display("FAIL abort_ram: got %0d expected 7", out_data); end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      step(ains(32767), 1'b1);
      step(cins(0, C_ZERO, 3'b000, 3'b111), 1'b1);
      n_checks++; if (pc !== 15'h7FFF) begin n_errors++; $display("FAIL wrap_jump: got %h expected 7fff", pc); end
      step(ains(0), 1'b1);
      n_checks++; if (pc !== 15'd0) begin n_errors++; $display("FAIL wrap_pc: got %h expected 0", pc); end
   endtask

   task automatic test_wrap32();
      do_reset();
      step32({16'hFFFF, cins(0, C_NEG1, DD, 0)});
      step32(32'd16384);
      step32({16'hFFFF, cins(0, C_D, DM, 0)});
      n_checks++; if (out32 !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL w32_neg1: got %h expected ffffffff", out32); end
      n_checks++; if (ov32 !== 1'b1) begin n_errors++; $display("FAIL w32_ov: got %b expected 1", ov32); end
      step32({16'hFFFF, cins(0, C_DP1, DD, 0)});
      step32({16'hFFFF, cins(0, C_D, DM, 0)});
      n_checks++; if (out32 !== 32'd0) begin n_errors++; $display("FAIL w32_wrap: got %h expected 0", out32); end
      n_checks++; if (pc32 !== 15'd5) begin n_errors++; $display("FAIL w32_pc: got %h expected 5", pc32); end
   endtask

   task automatic test_random();
      int halt_cycles;
      halt_cycles = 0;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         kbd = 16'($urandom);
         step(gen_instr(), $urandom_range(0, 9) < 8);
         n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc %0d: got %h expected %h", i, pc, m_pc); end
         n_checks++; if (out_data !== m_out) begin n_errors++; $display("FAIL rnd_out %0d: got %h expected %h", i, out_data, m_out); end
         n_checks++; if (out_valid !== m_outv) begin n_errors++; $display("FAIL rnd_ov %0d: got %b expected %b", i, out_valid, m_outv); end
         n_checks++; if (halted !== m_halt) begin n_errors++; $display("FAIL rnd_halted %0d: got %b expected %b", i, halted, m_halt); end
         if (m_halt) begin
            halt_cycles++;
            if (halt_cycles > 3) begin
               do_reset();
               halt_cycles = 0;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_out_sum();
      test_jump();
      test_am_update();
      test_kbd();
      test_stall();
      test_halt();
      test_reset_abort();
      test_pc_wrap();
      test_wrap32();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
